sample_ram_arb: RTL and testbench

SAMPLE_RAM_ARB -- requirements
Module: sample_ram_arb

---
 rtl/sample_ram_arb_pkg.sv | 29 ++
 rtl/sample_ram_wptr.sv | 86 ++++++++
 rtl/sample_ram_arb.sv | 199 +++++++++++++++++++
 tb/tb_sample_ram_arb.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_ram_arb_pkg.sv
// Shared state encodings, grant-select codes and address-window helper for sample_ram_arb.
package sample_ram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAP  = 2'd1,
        ST_BUS  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GSEL_NONE = 2'd0,
        GSEL_CAP  = 2'd1,
        GSEL_BUS  = 2'd2
    } gsel_t;

    // 33-bit compare so a window ending at 2^32 does not overflow.
    function automatic logic addr_in_window(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input int unsigned logsize);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + (33'd1 << logsize);
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/sample_ram_wptr.sv
// Capture write pointer with arm/stop control, linear-full detection and optional ring wrap
// (ring mode compiled in with SAMPLE_RAM_ARB_WRAP_EN).
module sample_ram_wptr
    import sample_ram_arb_pkg::*;
#(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arm,
    input  logic          stop,
    input  logic          wrap,
    input  logic          grant,
    output logic [AW-1:0] ptr,
    output logic          full,
    output logic          wrapped,
    output logic          armed
);

    localparam logic [AW-1:0] LAST = {AW{1'b1}};
    localparam logic [AW-1:0] ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic          wrap_on_s;
    logic [AW-1:0] ptr_r;
    logic          full_r;
    logic          armed_r;

`ifdef SAMPLE_RAM_ARB_WRAP_EN
    logic wrapped_r;

    assign wrap_on_s = wrap;
    assign wrapped   = wrapped_r;

    // Sticky ring-wrap flag, cleared by a new arm.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrapped_r <= 1'b0;
        end else if (arm) begin
            wrapped_r <= 1'b0;
        end else if (grant && (ptr_r == LAST) && wrap_on_s) begin
            wrapped_r <= 1'b1;
        end else begin
            wrapped_r <= wrapped_r;
        end
    end
`else
    logic unused_wrap_s;

    assign unused_wrap_s = wrap;
    assign wrap_on_s     = 1'b0;
    assign wrapped       = 1'b0;
`endif

    // Pointer, full and armed state; arm takes priority over stop.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r   <= {AW{1'b0}};
            full_r  <= 1'b0;
            armed_r <= 1'b0;
        end else if (arm) begin
            ptr_r   <= {AW{1'b0}};
            full_r  <= 1'b0;
            armed_r <= 1'b1;
        end else begin
            armed_r <= stop ? 1'b0 : armed_r;
            if (grant) begin
                if (ptr_r != LAST) begin
                    ptr_r <= ptr_r + ONE;
                end else if (wrap_on_s) begin
                    ptr_r <= {AW{1'b0}};
                end else begin
                    // Linear capture ends on the last word; pointer parks there.
                    full_r  <= 1'b1;
                    armed_r <= 1'b0;
                end
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    assign ptr   = ptr_r;
    assign full  = full_r;
    assign armed = armed_r;

endmodule

// File: rtl/sample_ram_arb.sv
// Arbitrates one external single-port RAM between a bus slave port and a streaming capture port.
// Ring-buffer capture is enabled by defining SAMPLE_RAM_ARB_WRAP_EN.
module sample_ram_arb
    import sample_ram_arb_pkg::*;
#(
    parameter logic [31:0] ADDR      = 32'h0000_0000,
    parameter int          LOGSIZE   = 16,
    parameter int          BURST_MAX = 8
) (
    input  logic                 bus_clk,
    input  logic                 bus_reset,
    input  logic [31:0]          bus_addr,
    input  logic [31:0]          bus_wr_data,
    input  logic [3:0]           bus_be,
    input  logic                 bus_we,
    input  logic                 bus_re,
    output logic [31:0]          bus_rd_data,
    output logic                 bus_rd_ack,
    output logic                 bus_wr_ack,
    input  logic                 cap_arm,
    input  logic                 cap_stop,
    input  logic                 cap_wrap,
    input  logic                 cap_valid,
    input  logic [31:0]          cap_data,
    output logic                 cap_ready,
    output logic [LOGSIZE-3:0]   cap_ptr,
    output logic                 cap_full,
    output logic                 cap_wrapped,
    output logic [3:0]           ram_we,
    output logic [LOGSIZE-3:0]   ram_addr,
    output logic [31:0]          ram_wr_data,
    input  logic [31:0]          ram_rd_data
);

    localparam int AW = LOGSIZE - 2;
    localparam int RW = $clog2(BURST_MAX + 1);
    localparam logic [RW-1:0] BURST_LIM = RW'(BURST_MAX);
    localparam logic [RW-1:0] RUN_ONE   = {{(RW-1){1'b0}}, 1'b1};

    arb_state_t    state_r;
    logic          ack_we_r;
    logic [RW-1:0] run_cnt_r;

    logic          pend_valid_r;
    logic          pend_we_r;
    logic [AW-1:0] pend_addr_r;
    logic [31:0]   pend_data_r;
    logic [3:0]    pend_be_r;

    logic          hit_s;
    logic          bus_req_s;
    logic          cap_ok_s;
    gsel_t         gsel_s;
    logic          bus_grant_s;
    logic          cap_grant_s;
    logic          armed_s;
    logic          eff_we_s;
    logic [AW-1:0] eff_addr_s;
    logic [31:0]   eff_data_s;
    logic [3:0]    eff_be_s;

    assign hit_s     = (bus_we | bus_re) & ~bus_reset & addr_in_window(bus_addr, ADDR, LOGSIZE);
    assign bus_req_s = (pend_valid_r | hit_s) & ~bus_reset;
    assign cap_ok_s  = armed_s & cap_valid & ~cap_full & ~bus_reset;

    // Bus request view: the latched request if one waits, else the live strobe.
    always_comb begin
        eff_we_s   = 1'b0;
        eff_addr_s = {AW{1'b0}};
        eff_data_s = 32'h0000_0000;
        eff_be_s   = 4'h0;
        if (pend_valid_r) begin
            eff_we_s   = pend_we_r;
            eff_addr_s = pend_addr_r;
            eff_data_s = pend_data_r;
            eff_be_s   = pend_be_r;
        end else begin
            eff_we_s   = bus_we;
            eff_addr_s = bus_addr[LOGSIZE-1:2];
            eff_data_s = bus_wr_data;
            eff_be_s   = bus_be;
        end
    end

    // Grant select: bus wins when capture cannot go or its burst budget is spent.
    always_comb begin
        gsel_s = GSEL_NONE;
        if (bus_req_s && (!cap_ok_s || (run_cnt_r == BURST_LIM))) begin
            gsel_s = GSEL_BUS;
        end else if (cap_ok_s) begin
            gsel_s = GSEL_CAP;
        end else begin
            gsel_s = GSEL_NONE;
        end
    end

    assign bus_grant_s = (gsel_s == GSEL_BUS);
    assign cap_grant_s = (gsel_s == GSEL_CAP);
    assign cap_ready   = cap_grant_s;

    // RAM port mux driven by the current owner.
    always_comb begin
        ram_we      = 4'h0;
        ram_addr    = {AW{1'b0}};
        ram_wr_data = 32'h0000_0000;
        case (gsel_s)
            GSEL_BUS: begin
                ram_we      = eff_we_s ? eff_be_s : 4'h0;
                ram_addr    = eff_addr_s;
                ram_wr_data = eff_data_s;
            end
            GSEL_CAP: begin
                ram_we      = 4'hF;
                ram_addr    = cap_ptr;
                ram_wr_data = cap_data;
            end
            default: begin
                ram_we      = 4'h0;
                ram_addr    = {AW{1'b0}};
                ram_wr_data = 32'h0000_0000;
            end
        endcase
    end

    // Arbiter state records last cycle's owner; the acks are decoded from it.
    always_ff @(posedge bus_clk) begin
        if (bus_reset) begin
            state_r  <= ST_IDLE;
            ack_we_r <= 1'b0;
        end else begin
            case (gsel_s)
                GSEL_BUS: begin
                    state_r  <= ST_BUS;
                    ack_we_r <= eff_we_s;
                end
                GSEL_CAP: begin
                    state_r  <= ST_CAP;
                    ack_we_r <= 1'b0;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    ack_we_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus_wr_ack  = (state_r == ST_BUS) & ack_we_r;
    assign bus_rd_ack  = (state_r == ST_BUS) & ~ack_we_r;
    assign bus_rd_data = bus_rd_ack ? ram_rd_data : 32'h0000_0000;

    // Consecutive capture grant counter, saturating at the burst limit.
    always_ff @(posedge bus_clk) begin
        if (bus_reset) begin
            run_cnt_r <= {RW{1'b0}};
        end else if (cap_grant_s) begin
            run_cnt_r <= (run_cnt_r == BURST_LIM) ? run_cnt_r : run_cnt_r + RUN_ONE;
        end else begin
            run_cnt_r <= {RW{1'b0}};
        end
    end

    // Pending register: a strobe that is not served in its own cycle waits here.
    always_ff @(posedge bus_clk) begin
        if (bus_reset) begin
            pend_valid_r <= 1'b0;
            pend_we_r    <= 1'b0;
            pend_addr_r  <= {AW{1'b0}};
            pend_data_r  <= 32'h0000_0000;
            pend_be_r    <= 4'h0;
        end else if (bus_grant_s) begin
            pend_valid_r <= 1'b0;
        end else if (hit_s) begin
            pend_valid_r <= 1'b1;
            pend_we_r    <= bus_we;
            pend_addr_r  <= bus_addr[LOGSIZE-1:2];
            pend_data_r  <= bus_wr_data;
            pend_be_r    <= bus_be;
        end else begin
            pend_valid_r <= pend_valid_r;
        end
    end

    sample_ram_wptr #(
        .AW (AW)
    ) u_wptr (
        .clk     (bus_clk),
        .reset   (bus_reset),
        .arm     (cap_arm),
        .stop    (cap_stop),
        .wrap    (cap_wrap),
        .grant   (cap_grant_s),
        .ptr     (cap_ptr),
        .full    (cap_full),
        .wrapped (cap_wrapped),
        .armed   (armed_s)
    );

endmodule

// File: tb/tb_sample_ram_arb.sv
// Self-checking bench for sample_ram_arb with a behavioural byte-enable RAM and an ack scoreboard.
module tb_sample_ram_arb;

    localparam int LOGSIZE   = 6;
    localparam int AW        = LOGSIZE - 2;
    localparam int BURST_MAX = 8;
`ifdef SAMPLE_RAM_ARB_WRAP_EN
    localparam bit WRAP_BUILD = 1'b1;
`else
    localparam bit WRAP_BUILD = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [31:0] data;
    } exp_t;

    logic          bus_clk = 1'b0;
    logic          bus_reset;
    logic [31:0]   bus_addr;
    logic [31:0]   bus_wr_data;
    logic [3:0]    bus_be;
    logic          bus_we;
    logic          bus_re;
    logic [31:0]   bus_rd_data;
    logic          bus_rd_ack;
    logic          bus_wr_ack;
    logic          cap_arm;
    logic          cap_stop;
    logic          cap_wrap;
    logic          cap_valid;
    logic [31:0]   cap_data;
    logic          cap_ready;
    logic [AW-1:0] cap_ptr;
    logic          cap_full;
    logic          cap_wrapped;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wr_data;
    logic [31:0]   ram_rd_data;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] shadow  [16];
    logic [31:0] ram_mem [16];

    sample_ram_arb #(
        .ADDR      (32'h0000_0000),
        .LOGSIZE   (LOGSIZE),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .bus_clk     (bus_clk),
        .bus_reset   (bus_reset),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .bus_be      (bus_be),
        .bus_we      (bus_we),
        .bus_re      (bus_re),
        .bus_rd_data (bus_rd_data),
        .bus_rd_ack  (bus_rd_ack),
        .bus_wr_ack  (bus_wr_ack),
        .cap_arm     (cap_arm),
        .cap_stop    (cap_stop),
        .cap_wrap    (cap_wrap),
        .cap_valid   (cap_valid),
        .cap_data    (cap_data),
        .cap_ready   (cap_ready),
        .cap_ptr     (cap_ptr),
        .cap_full    (cap_full),
        .cap_wrapped (cap_wrapped),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_data (ram_rd_data)
    );

    initial forever #5 bus_clk = ~bus_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] smp(input int n);
        return 32'hC0DE_0000 + 32'(n);
    endfunction

    // Byte-enable single-port RAM with one-cycle read latency.
    always @(posedge bus_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wr_data[8*b +: 8];
        end
        ram_rd_data <= ram_mem[ram_addr];
    end

    // Ack monitor: pops the scoreboard on every ack and checks idle read data.
    always @(negedge bus_clk) begin
        if (!bus_rd_ack) check("rd_data_idle", bus_rd_data, 32'h0);
        if (bus_rd_ack || bus_wr_ack) begin
            if (exp_q.size() == 0) begin
                check("unexp_ack", {30'd0, bus_wr_ack, bus_rd_ack}, 32'h0);
            end else begin
                mon_e = exp_q.pop_front();
                check("ack_kind", {30'd0, bus_wr_ack, bus_rd_ack}, mon_e.we ? 32'h2 : 32'h1);
                if (!mon_e.we) check("rd_data", bus_rd_data, mon_e.data);
            end
        end
    end

    task automatic bus_op(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input logic in_range);
        exp_t e;
        logic [AW-1:0] w;
        w = addr[LOGSIZE-1:2];
        @(negedge bus_clk);
        bus_addr = addr; bus_wr_data = data; bus_be = be; bus_we = we; bus_re = !we;
        #1;
        if (in_range) begin
            e.we   = we;
            e.data = shadow[w];
            exp_q.push_back(e);
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) shadow[w][8*b +: 8] = data[8*b +: 8];
                end
            end
            check("grant_we", 32'(ram_we), we ? 32'(be) : 32'h0);
            check("grant_addr", 32'(ram_addr), 32'(w));
            if (we) check("grant_wdata", ram_wr_data, data);
        end else begin
            check("oor_we", 32'(ram_we), 32'h0);
        end
        @(negedge bus_clk);
        bus_we = 1'b0; bus_re = 1'b0;
        #1;
        check("one_cycle_latency", 32'(exp_q.size()), 32'h0);
        for (int i = 0; i < 12 && exp_q.size() != 0; i++) begin
            @(negedge bus_clk); #1;
        end
        check("ack_drained", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        int   nacc;
        int   run;
        int   bus_c;
        int   ack_c;
        logic got_bus;
        exp_t e;

        bus_reset = 1'b1; bus_addr = 32'h0; bus_wr_data = 32'h0; bus_be = 4'h0;
        bus_we = 1'b0; bus_re = 1'b0; cap_arm = 1'b0; cap_stop = 1'b0; cap_wrap = 1'b0;
        cap_valid = 1'b0; cap_data = 32'h0;
        for (int i = 0; i < 16; i++) shadow[i] = 32'h0;

        repeat (2) @(negedge bus_clk);
        #1;
        check("rst_ram_we", 32'(ram_we), 32'h0);
        check("rst_cap_ready", 32'(cap_ready), 32'h0);
        check("rst_acks", {30'd0, bus_wr_ack, bus_rd_ack}, 32'h0);
        check("rst_cap_ptr", 32'(cap_ptr), 32'h0);
        check("rst_flags", {30'd0, cap_full, cap_wrapped}, 32'h0);
        bus_reset = 1'b0;

        // Basic bus path, byte enables, top-of-window boundary and out-of-range strobes.
        bus_op(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1);
        bus_op(1'b0, 32'h10, 32'h0, 4'hF, 1'b1);
        bus_op(1'b1, 32'h14, 32'hAABB_CCDD, 4'hF, 1'b1);
        bus_op(1'b1, 32'h14, 32'h1122_3344, 4'b0101, 1'b1);
        bus_op(1'b0, 32'h14, 32'h0, 4'hF, 1'b1);
        check("be_merge_model", shadow[5], 32'hAA22_CC44);
        bus_op(1'b1, 32'h3C, 32'h1234_5678, 4'hF, 1'b1);
        bus_op(1'b0, 32'h3C, 32'h0, 4'hF, 1'b1);
        bus_op(1'b1, 32'h40, 32'hFFFF_FFFF, 4'hF, 1'b0);
        bus_op(1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 1'b0);

        // Capture burst against a bus read strobed on the first capture cycle.
        @(negedge bus_clk); cap_arm = 1'b1;
        @(negedge bus_clk); cap_arm = 1'b0;
        nacc = 0; run = 0; got_bus = 1'b0; bus_c = -1; ack_c = -1;
        cap_valid = 1'b1; cap_data = smp(1);
        bus_addr = 32'h10; bus_re = 1'b1;
        e.we = 1'b0; e.data = smp(5); exp_q.push_back(e);
        for (int c = 0; c < 12; c++) begin
            #1;
            if (bus_rd_ack && ack_c < 0) ack_c = c;
            if (got_bus && c == bus_c + 1) check("cap_resume", 32'(cap_ready), 32'h1);
            if (cap_ready) begin
                if (!got_bus) run++;
                shadow[nacc % 16] = smp(nacc + 1);
                nacc++;
            end else if (!got_bus) begin
                got_bus = 1'b1;
                bus_c = c;
                check("burst_len", 32'(run), 32'(BURST_MAX));
                check("bus_rd_we", 32'(ram_we), 32'h0);
                check("bus_rd_addr", 32'(ram_addr), 32'h4);
            end
            @(negedge bus_clk);
            bus_re = 1'b0; cap_data = smp(nacc + 1);
        end
        cap_valid = 1'b0;
        check("bus_granted", 32'(got_bus), 32'h1);
        check("rd_latency", 32'(ack_c), 32'(BURST_MAX + 1));
        check("burst_ptr", 32'(cap_ptr), 32'(nacc));
        cap_stop = 1'b1;
        @(negedge bus_clk); cap_stop = 1'b0;

        // Twenty samples with cap_wrap high: ring capture if compiled in, linear otherwise.
        @(negedge bus_clk); cap_arm = 1'b1;
        @(negedge bus_clk); cap_arm = 1'b0;
        cap_wrap = 1'b1; cap_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cap_data = smp(200 + k);
            #1;
            check("cap_ready", 32'(cap_ready), 32'(WRAP_BUILD || k < 16));
            check("cap_full_step", 32'(cap_full), 32'(!WRAP_BUILD && k >= 16));
            if (WRAP_BUILD || k < 16) shadow[k % 16] = smp(200 + k);
            @(negedge bus_clk);
        end
        cap_valid = 1'b0;
        #1;
        check("cap_full_end", 32'(cap_full), 32'(!WRAP_BUILD));
        check("cap_wrapped_end", 32'(cap_wrapped), 32'(WRAP_BUILD));
        check("cap_ptr_end", 32'(cap_ptr), WRAP_BUILD ? 32'h4 : 32'hF);
        cap_wrap = 1'b0;
        for (int w = 0; w < 16; w++) bus_op(1'b0, 32'(w * 4), 32'h0, 4'hF, 1'b1);

        // Arm and stop together: arm wins.
        @(negedge bus_clk); cap_arm = 1'b1; cap_stop = 1'b1;
        @(negedge bus_clk); cap_arm = 1'b0; cap_stop = 1'b0;
        #1;
        check("arm_stop_ptr", 32'(cap_ptr), 32'h0);
        check("arm_stop_flags", {30'd0, cap_full, cap_wrapped}, 32'h0);
        cap_valid = 1'b1; cap_data = smp(300);
        #1;
        check("arm_stop_armed", 32'(cap_ready), 32'h1);
        shadow[0] = smp(300);
        @(negedge bus_clk); cap_valid = 1'b0;
        #1;
        check("arm_stop_ptr1", 32'(cap_ptr), 32'h1);
        cap_stop = 1'b1;
        @(negedge bus_clk); cap_stop = 1'b0; cap_valid = 1'b1;
        #1;
        check("stopped_no_ready", 32'(cap_ready), 32'h0);
        cap_valid = 1'b0;

        // Reset while a bus read waits behind a capture burst: no ack may follow.
        @(negedge bus_clk); cap_arm = 1'b1;
        @(negedge bus_clk); cap_arm = 1'b0;
        cap_valid = 1'b1; cap_data = smp(400); bus_addr = 32'h20; bus_re = 1'b1;
        #1;
        check("pre_rst_cap", 32'(cap_ready), 32'h1);
        @(negedge bus_clk); bus_re = 1'b0;
        @(negedge bus_clk); bus_reset = 1'b1;
        @(negedge bus_clk); bus_reset = 1'b0;
        #1;
        check("post_rst_ram_we", 32'(ram_we), 32'h0);
        check("post_rst_cap_ready", 32'(cap_ready), 32'h0);
        check("post_rst_rd_data", bus_rd_data, 32'h0);
        check("post_rst_acks", {30'd0, bus_wr_ack, bus_rd_ack}, 32'h0);
        check("post_rst_ptr", 32'(cap_ptr), 32'h0);
        for (int i = 0; i < 12; i++) begin
            @(negedge bus_clk); #1;
            check("post_rst_quiet", 32'(ram_we), 32'h0);
        end
        cap_valid = 1'b0;
        repeat (2) @(negedge bus_clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
